// File: rtl/yags_pkg.sv
// Shared types and helpers for the YAGS predictor update path.
package yags_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_WEAK_T  = 2'b10;
    localparam ctr_t CTR_WEAK_NT = 2'b01;

    // Table writes derived from one resolved branch.
    typedef struct packed {
        logic choice_we;
        ctr_t choice_wdata;
        logic cache_we;
        logic cache_sel;
        ctr_t cache_wdata;
    } upd_t;

    typedef enum logic {
        ST_IDLE,
        ST_ISSUE
    } state_t;

    // Two-bit saturating counter step towards the outcome.
    function automatic ctr_t sat_update(input ctr_t c, input logic taken);
        if (taken) begin
            return (c == 2'b11) ? c : c + 2'b01;
        end
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

endpackage

// File: rtl/yags_res_fifo.sv
// Parameterised synchronous FIFO with occupancy count; DEPTH is a power of two.
module yags_res_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Pointer, count and storage next-state.
    always_comb begin
        do_push  = push && (count_q != CNT_W'(DEPTH));
        do_pop   = pop && (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Control state resets; storage holds data only.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/yags_update_ctrl.sv
// YAGS update controller: buffers resolved branches, derives choice-PHT and
// exception-cache writes, issues them on write-port grants, keeps statistics.
module yags_update_ctrl
    import yags_pkg::*;
#(
    parameter int unsigned PHT_IDX_W   = 10,
    parameter int unsigned CACHE_IDX_W = 8,
    parameter int unsigned TAG_W       = 6,
    parameter int unsigned GHR_W       = 8,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   res_valid,
    output logic                   res_ready,
    input  logic [31:0]            res_pc,
    input  logic                   res_taken,
    input  logic [GHR_W-1:0]       res_ghr,
    input  logic [1:0]             res_choice_ctr,
    input  logic                   res_cache_hit,
    input  logic [1:0]             res_cache_ctr,
    input  logic                   res_mispredict,
    input  logic                   wr_grant,
    output logic                   choice_we,
    output logic [PHT_IDX_W-1:0]   choice_idx,
    output logic [1:0]             choice_wdata,
    output logic                   cache_we,
    output logic                   cache_sel,
    output logic [CACHE_IDX_W-1:0] cache_idx,
    output logic [TAG_W-1:0]       cache_tag,
    output logic [1:0]             cache_wdata,
    output logic [31:0]            stat_branches,
    output logic [31:0]            stat_mispredicts,
    output logic                   idle
);
    localparam int unsigned REC_W = PHT_IDX_W + CACHE_IDX_W + TAG_W + 6;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    // Indices and tag are formed at push time so only the needed bits are buffered.
    logic [REC_W-1:0]       push_rec, head_rec;
    logic [CNT_W-1:0]       fifo_count;
    logic                   fifo_push, fifo_pop, fifo_empty;
    logic [PHT_IDX_W-1:0]   h_cidx;
    logic [CACHE_IDX_W-1:0] h_kidx;
    logic [TAG_W-1:0]       h_tag;
    logic                   h_taken, h_hit;
    ctr_t                   h_cc, h_kc, choice_new, cache_new;
    upd_t                   upd;
    logic                   unused_in_bits;

    assign push_rec = {res_pc[PHT_IDX_W+1:2],
                       res_pc[CACHE_IDX_W+1:2] ^ res_ghr[CACHE_IDX_W-1:0],
                       res_pc[CACHE_IDX_W+TAG_W+1:CACHE_IDX_W+2],
                       res_taken, res_choice_ctr, res_cache_hit, res_cache_ctr};
    assign {h_cidx, h_kidx, h_tag, h_taken, h_cc, h_hit, h_kc} = head_rec;
    assign unused_in_bits = ^{res_pc, res_ghr};
    assign fifo_empty     = (fifo_count == '0);
    assign fifo_push      = res_valid && res_ready;

    yags_res_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_rec),
        .pop       (fifo_pop),
        .pop_data  (head_rec),
        .count     (fifo_count)
    );

    state_t                 state_q, state_d;
    upd_t                   iss_q, iss_d;
    logic [PHT_IDX_W-1:0]   iss_cidx_q, iss_cidx_d;
    logic [CACHE_IDX_W-1:0] iss_kidx_q, iss_kidx_d;
    logic [TAG_W-1:0]       iss_tag_q, iss_tag_d;
    logic [31:0]            stat_branches_q, stat_branches_d;
    logic [31:0]            stat_mispredicts_q, stat_mispredicts_d;
    logic                   fire;

    // YAGS update rules applied to the FIFO head record.
    always_comb begin
        upd              = '0;
        choice_new       = sat_update(h_cc, h_taken);
        cache_new        = sat_update(h_kc, h_taken);
        upd.choice_wdata = choice_new;
        upd.choice_we    = (choice_new != h_cc) &&
                           !((h_cc[1] != h_taken) && h_hit && (h_kc[1] == h_taken));
        if (h_hit) begin
            upd.cache_we    = (cache_new != h_kc);
            upd.cache_sel   = !h_cc[1];
            upd.cache_wdata = cache_new;
        end else if (h_cc[1] != h_taken) begin
            upd.cache_we    = 1'b1;
            upd.cache_sel   = h_taken;
            upd.cache_wdata = h_taken ? CTR_WEAK_T : CTR_WEAK_NT;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state and FIFO pop.
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (wr_grant) begin
                    if (!fifo_empty) fifo_pop = 1'b1;
                    else             state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: writes only in a granted ISSUE cycle, never during reset.
    always_comb begin
        fire         = (state_q == ST_ISSUE) && wr_grant && !reset;
        choice_we    = fire && iss_q.choice_we;
        choice_idx   = iss_cidx_q;
        choice_wdata = iss_q.choice_wdata;
        cache_we     = fire && iss_q.cache_we;
        cache_sel    = iss_q.cache_sel;
        cache_idx    = iss_kidx_q;
        cache_tag    = iss_tag_q;
        cache_wdata  = iss_q.cache_wdata;
        res_ready    = (fifo_count < CNT_W'(FIFO_DEPTH));
        idle         = fifo_empty && (state_q == ST_IDLE);
    end

    // Issue register load and statistics next-state.
    always_comb begin
        iss_d              = iss_q;
        iss_cidx_d         = iss_cidx_q;
        iss_kidx_d         = iss_kidx_q;
        iss_tag_d          = iss_tag_q;
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (fifo_pop) begin
            iss_d      = upd;
            iss_cidx_d = h_cidx;
            iss_kidx_d = h_kidx;
            iss_tag_d  = h_tag;
        end
        if (fifo_push) begin
            stat_branches_d = stat_branches_q + 32'd1;
            if (res_mispredict) stat_mispredicts_d = stat_mispredicts_q + 32'd1;
        end
    end

    // Issue register and statistics counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            iss_q              <= '0;
            iss_cidx_q         <= '0;
            iss_kidx_q         <= '0;
            iss_tag_q          <= '0;
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            iss_q              <= iss_d;
            iss_cidx_q         <= iss_cidx_d;
            iss_kidx_q         <= iss_kidx_d;
            iss_tag_q          <= iss_tag_d;
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_yags_update_ctrl.sv
// Self-checking bench for yags_update_ctrl: directed scenarios followed by
// random traffic, compared every cycle against a queue-based reference model.
module tb_yags_update_ctrl;

    logic        clk = 1'b0;
    logic        reset, res_valid, res_ready, res_taken, res_cache_hit, res_mispredict;
    logic [31:0] res_pc;
    logic [7:0]  res_ghr;
    logic [1:0]  res_choice_ctr, res_cache_ctr;
    logic        wr_grant, choice_we, cache_we, cache_sel, idle;
    logic [9:0]  choice_idx;
    logic [1:0]  choice_wdata, cache_wdata;
    logic [7:0]  cache_idx;
    logic [5:0]  cache_tag;
    logic [31:0] stat_branches, stat_mispredicts;

    yags_update_ctrl #(
        .PHT_IDX_W   (10),
        .CACHE_IDX_W (8),
        .TAG_W       (6),
        .GHR_W       (8),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk (clk), .reset (reset),
        .res_valid (res_valid), .res_ready (res_ready), .res_pc (res_pc),
        .res_taken (res_taken), .res_ghr (res_ghr), .res_choice_ctr (res_choice_ctr),
        .res_cache_hit (res_cache_hit), .res_cache_ctr (res_cache_ctr),
        .res_mispredict (res_mispredict), .wr_grant (wr_grant),
        .choice_we (choice_we), .choice_idx (choice_idx), .choice_wdata (choice_wdata),
        .cache_we (cache_we), .cache_sel (cache_sel), .cache_idx (cache_idx),
        .cache_tag (cache_tag), .cache_wdata (cache_wdata),
        .stat_branches (stat_branches), .stat_mispredicts (stat_mispredicts),
        .idle (idle)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [7:0]  ghr;
        logic [1:0]  cc;
        logic        hit;
        logic [1:0]  kc;
        logic        mis;
    } rec_t;

    typedef struct packed {
        logic       cwe;
        logic [9:0] cidx;
        logic [1:0] cwd;
        logic       kwe;
        logic       ksel;
        logic [7:0] kidx;
        logic [5:0] ktag;
        logic [1:0] kwd;
    } exp_t;

    // Reference model: pending records, the one being issued, and counters.
    rec_t        mq[$];
    rec_t        cur;
    bit          have_cur;
    logic [31:0] m_br, m_mis;
    int unsigned tests, fails;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] clamp(input int v);
        int c;
        c = (v < 0) ? 0 : (v > 3) ? 3 : v;
        return 2'(c);
    endfunction

    // Expected writes for one record, computed from the update rules with plain arithmetic.
    function automatic exp_t rules(input rec_t r);
        exp_t e;
        int   step_dir;
        e        = '0;
        step_dir = r.taken ? 1 : -1;
        e.cidx   = 10'((r.pc >> 2) % 1024);
        e.kidx   = 8'(((r.pc >> 2) ^ {24'd0, r.ghr}) % 256);
        e.ktag   = 6'((r.pc >> 10) % 64);
        e.cwd    = clamp(int'(r.cc) + step_dir);
        e.cwe    = (e.cwd != r.cc) && !((r.cc[1] != r.taken) && r.hit && (r.kc[1] == r.taken));
        if (r.hit) begin
            e.kwd  = clamp(int'(r.kc) + step_dir);
            e.kwe  = (e.kwd != r.kc);
            e.ksel = !r.cc[1];
        end else if (r.cc[1] != r.taken) begin
            e.kwe  = 1'b1;
            e.ksel = r.taken;
            e.kwd  = r.taken ? 2'd2 : 2'd1;
        end
        return e;
    endfunction

    function automatic rec_t mk(input logic [31:0] pc, input logic t, input logic [1:0] cc,
                                input logic h, input logic [1:0] kc, input logic m);
        rec_t r;
        r.pc = pc; r.taken = t; r.ghr = 8'h00; r.cc = cc; r.hit = h; r.kc = kc; r.mis = m;
        return r;
    endfunction

    function automatic rec_t rnd_rec();
        rec_t r;
        r.pc    = $urandom;
        r.taken = 1'($urandom_range(0, 1));
        r.ghr   = 8'($urandom);
        r.cc    = 2'($urandom_range(0, 3));
        r.hit   = 1'($urandom_range(0, 1));
        r.kc    = 2'($urandom_range(0, 3));
        r.mis   = 1'($urandom_range(0, 1));
        return r;
    endfunction

    // One clock cycle: drive at negedge, check outputs before the edge, advance model.
    task automatic step(input logic v, input rec_t r, input logic g, input logic rst, output bit acc);
        exp_t e;
        bit   live;
        reset = rst; res_valid = v; wr_grant = g;
        res_pc = r.pc; res_taken = r.taken; res_ghr = r.ghr; res_choice_ctr = r.cc;
        res_cache_hit = r.hit; res_cache_ctr = r.kc; res_mispredict = r.mis;
        #1;
        live = have_cur && g && !rst;
        e    = rules(cur);
        chk("res_ready", 32'(res_ready), 32'(mq.size() < 4));
        chk("idle", 32'(idle), 32'(mq.size() == 0 && !have_cur));
        chk("stat_branches", stat_branches, m_br);
        chk("stat_mispredicts", stat_mispredicts, m_mis);
        chk("choice_we", 32'(choice_we), 32'(live && e.cwe));
        chk("cache_we", 32'(cache_we), 32'(live && e.kwe));
        if (live && e.cwe) begin
            chk("choice_idx", 32'(choice_idx), 32'(e.cidx));
            chk("choice_wdata", 32'(choice_wdata), 32'(e.cwd));
        end
        if (live && e.kwe) begin
            chk("cache_sel", 32'(cache_sel), 32'(e.ksel));
            chk("cache_idx", 32'(cache_idx), 32'(e.kidx));
            chk("cache_tag", 32'(cache_tag), 32'(e.ktag));
            chk("cache_wdata", 32'(cache_wdata), 32'(e.kwd));
        end
        @(posedge clk);
        acc = 1'b0;
        if (rst) begin
            mq.delete();
            have_cur = 1'b0;
            m_br     = '0;
            m_mis    = '0;
        end else begin
            acc = v && (mq.size() < 4);
            if (have_cur && g) have_cur = 1'b0;
            if (!have_cur && mq.size() != 0) begin
                cur      = mq.pop_front();
                have_cur = 1'b1;
            end
            if (acc) begin
                mq.push_back(r);
                m_br++;
                if (r.mis) m_mis++;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rec_t        r0, r;
        bit          acc;
        int unsigned k;
        r0 = '0; tests = 0; fails = 0; have_cur = 1'b0; m_br = '0; m_mis = '0; cur = '0;
        reset = 1'b1; res_valid = 1'b0; wr_grant = 1'b0;
        res_pc = '0; res_taken = 1'b0; res_ghr = '0; res_choice_ctr = '0;
        res_cache_hit = 1'b0; res_cache_ctr = '0; res_mispredict = 1'b0;
        @(negedge clk);

        // Reset and post-reset state.
        step(0, r0, 0, 1, acc);
        step(0, r0, 0, 1, acc);
        step(0, r0, 1, 0, acc);

        // Allocation on a choice misprediction with no cache hit.
        step(1, mk(32'h0000_0040, 1, 2'b01, 0, 2'b00, 1), 1, 0, acc);
        repeat (3) step(0, r0, 1, 0, acc);

        // Cache hit agreeing with the outcome suppresses the choice write.
        step(1, mk(32'h0000_1044, 1, 2'b00, 1, 2'b10, 0), 1, 0, acc);
        repeat (3) step(0, r0, 1, 0, acc);

        // Back-pressure: no grant, fill buffer and issue slot, then release.
        for (int i = 0; i < 5; i++) begin
            r = rnd_rec(); k = 0;
            do begin step(1, r, 0, 0, acc); k++; end while (!acc && k < 8);
            chk("bp_accept", 32'(acc), 32'd1);
        end
        r = rnd_rec();
        repeat (3) step(1, r, 0, 0, acc);
        chk("bp_full_reject", 32'(acc), 32'd0);
        k = 0;
        do begin step(1, r, 1, 0, acc); k++; end while (!acc && k < 8);
        chk("bp_late_accept", 32'(acc), 32'd1);
        repeat (8) step(0, r0, 1, 0, acc);

        // Saturated counter, no writes; still retires on grant.
        step(1, mk(32'h0000_0080, 1, 2'b11, 0, 2'b00, 0), 1, 0, acc);
        step(1, mk(32'h0000_0084, 0, 2'b00, 1, 2'b00, 0), 1, 0, acc);
        repeat (4) step(0, r0, 1, 0, acc);

        // Reset while issuing with three records queued.
        for (int i = 0; i < 4; i++) step(1, rnd_rec(), 0, 0, acc);
        step(0, r0, 1, 1, acc);
        step(0, r0, 1, 0, acc);

        // Statistics wrap via backdoor preload.
        dut.stat_branches_q = 32'hFFFF_FFFF;
        m_br = 32'hFFFF_FFFF;
        step(1, rnd_rec(), 1, 0, acc);
        chk("stat_wrap", stat_branches, 32'd0);
        repeat (3) step(0, r0, 1, 0, acc);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), rnd_rec(), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 63) == 0), acc);
        end
        k = 0;
        while ((mq.size() != 0 || have_cur) && k < 20) begin
            step(0, r0, 1, 0, acc);
            k++;
        end
        step(0, r0, 1, 0, acc);
        chk("drain_idle", 32'(idle), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
